// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : run_ctrl
//  Brief    : CPU run/halt/single-step controller with cycle budget and
//             valid/ready register-file dump port.
//  Revision : 1.0
// ============================================================================
module run_ctrl #(
    parameter int CYCLE_LIMIT = 30,
    parameter int NUM_REGS    = 32,
    parameter int REG_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             dump_i,
    output logic             cpu_en_o,
    output logic             halted_o,
    output logic             done_o,
    output logic [31:0]      cycle_cnt_o,
    output logic [4:0]       rf_raddr_o,
    input  logic [REG_W-1:0] rf_rdata_i,
    output logic             dump_valid_o,
    input  logic             dump_ready_i,
    output logic [4:0]       dump_addr_o,
    output logic [REG_W-1:0] dump_data_o,
    output logic             dump_last_o
);

    localparam logic [31:0] c_limit    = 32'(CYCLE_LIMIT);
    localparam logic [4:0]  c_last_idx = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_HALT      = 3'd2,
        S_STEP      = 3'd3,
        S_DUMP_LOAD = 3'd4,
        S_DUMP_WAIT = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [4:0]         idx_q, idx_d;
    logic [4:0]         addr_q, addr_d;
    logic [REG_W-1:0]   data_q, data_d;
    logic               last_q, last_d;

    logic               w_cpu_en;
    logic [31:0]        w_cnt_inc;
    logic               w_limit_hit;

    assign w_cpu_en    = (state_q == S_RUN) || (state_q == S_STEP);
    assign w_cnt_inc   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    // Budget is judged on the count this edge will produce, so exactly
    // CYCLE_LIMIT enabled cycles happen before the forced halt.
    assign w_limit_hit = (c_limit != 32'd0) && (w_cnt_inc == c_limit);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;

        if (w_cpu_en) begin
            cnt_d = w_cnt_inc;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (w_limit_hit) begin
                    done_d  = 1'b1;
                    state_d = S_HALT;
                end else if (!start_i) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                // dump outranks step outranks start; a spent budget only
                // leaves the dump path open.
                if (dump_i) begin
                    idx_d   = '0;
                    state_d = S_DUMP_LOAD;
                end else if (!done_q && step_i) begin
                    state_d = S_STEP;
                end else if (!done_q && start_i) begin
                    state_d = S_RUN;
                end
            end
            S_STEP: begin
                if (w_limit_hit) begin
                    done_d = 1'b1;
                end
                state_d = S_HALT;
            end
            S_DUMP_LOAD: begin
                data_d  = rf_rdata_i;
                addr_d  = idx_q;
                last_d  = (idx_q == c_last_idx);
                state_d = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                if (dump_ready_i) begin
                    if (last_q) begin
                        state_d = S_HALT;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_DUMP_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cpu_en_o     = w_cpu_en;
    assign halted_o     = (state_q == S_HALT);
    assign done_o       = done_q;
    assign cycle_cnt_o  = cnt_q;
    assign rf_raddr_o   = (state_q == S_DUMP_LOAD) ? idx_q : 5'd0;
    assign dump_valid_o = (state_q == S_DUMP_WAIT);
    assign dump_addr_o  = addr_q;
    assign dump_data_o  = data_q;
    assign dump_last_o  = last_q && (state_q == S_DUMP_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_run_ctrl
//  Brief    : Self-checking bench for run_ctrl: vector table, directed
//             sequences and randomized traffic against a reference model.
//  Revision : 1.0
// ============================================================================
module tb_run_ctrl;

    localparam int LIMIT = 30;
    localparam int NREGS = 32;

    logic        clk_i;
    logic        rst_i;
    logic        start_i, step_i, dump_i, dump_ready_i;
    logic        cpu_en_o, halted_o, done_o, dump_valid_o, dump_last_o;
    logic [31:0] cycle_cnt_o, dump_data_o, rf_rdata;
    logic [4:0]  rf_raddr_o, dump_addr_o;

    logic        cpu_en0, halted0, done0, valid0, last0;
    logic [31:0] cnt0, data0, rf_rdata0;
    logic [4:0]  raddr0, addr0;

    logic [31:0] rf [NREGS];

    int n_checks = 0;
    int n_err    = 0;

    assign rf_rdata  = rf[rf_raddr_o];
    assign rf_rdata0 = rf[raddr0];

    run_ctrl #(.CYCLE_LIMIT(LIMIT), .NUM_REGS(NREGS), .REG_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .step_i(step_i),
        .dump_i(dump_i), .cpu_en_o(cpu_en_o), .halted_o(halted_o),
        .done_o(done_o), .cycle_cnt_o(cycle_cnt_o), .rf_raddr_o(rf_raddr_o),
        .rf_rdata_i(rf_rdata), .dump_valid_o(dump_valid_o),
        .dump_ready_i(dump_ready_i), .dump_addr_o(dump_addr_o),
        .dump_data_o(dump_data_o), .dump_last_o(dump_last_o)
    );

    run_ctrl #(.CYCLE_LIMIT(0), .NUM_REGS(NREGS), .REG_W(32)) dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .step_i(step_i),
        .dump_i(dump_i), .cpu_en_o(cpu_en0), .halted_o(halted0),
        .done_o(done0), .cycle_cnt_o(cnt0), .rf_raddr_o(raddr0),
        .rf_rdata_i(rf_rdata0), .dump_valid_o(valid0),
        .dump_ready_i(dump_ready_i), .dump_addr_o(addr0),
        .dump_data_o(data0), .dump_last_o(last0)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- reference model (behavioural) ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_STEP = 3, M_DUMP = 4;
    int          m_mode;
    logic [31:0] m_cnt;
    logic        m_done;
    int          m_beat;
    logic        m_loaded;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = '0; m_done = 1'b0; m_beat = 0; m_loaded = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic sp, input logic dm, input logic rd);
        case (m_mode)
            M_IDLE: if (st) m_mode = M_RUN;
            M_RUN, M_STEP: begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                if (LIMIT != 0 && m_cnt == 32'(LIMIT)) begin
                    m_done = 1'b1;
                    m_mode = M_HALT;
                end else if (m_mode == M_STEP || !st) begin
                    m_mode = M_HALT;
                end
            end
            M_HALT: begin
                if (dm) begin
                    m_mode = M_DUMP; m_beat = 0; m_loaded = 1'b0;
                end else if (!m_done && sp) m_mode = M_STEP;
                else if (!m_done && st) m_mode = M_RUN;
            end
            default: begin
                // each beat: one cycle to fetch, then wait for ready
                if (!m_loaded) m_loaded = 1'b1;
                else if (rd) begin
                    if (m_beat == NREGS - 1) m_mode = M_HALT;
                    else begin
                        m_beat++; m_loaded = 1'b0;
                    end
                end
            end
        endcase
    endtask

    task automatic check_model();
        logic ecpu, ehlt, evld;
        ecpu = (m_mode == M_RUN) || (m_mode == M_STEP);
        ehlt = (m_mode == M_HALT);
        evld = (m_mode == M_DUMP) && m_loaded;
        chk("model_state", 64'({cpu_en_o, halted_o, done_o, dump_valid_o, cycle_cnt_o}),
            64'({ecpu, ehlt, m_done, evld, m_cnt}));
        if (evld)
            chk("model_beat", 64'({dump_last_o, dump_addr_o, dump_data_o}),
                64'({(m_beat == NREGS - 1), 5'(m_beat), rf[m_beat]}));
    endtask

    task automatic cyc(input logic st, input logic sp, input logic dm, input logic rd);
        start_i = st; step_i = sp; dump_i = dm; dump_ready_i = rd;
        model_edge(st, sp, dm, rd);
        @(posedge clk_i);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        start_i = 0; step_i = 0; dump_i = 0; dump_ready_i = 0;
        rst_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        chk("reset_out", 64'({cpu_en_o, halted_o, done_o, dump_valid_o, dump_last_o,
                              cycle_cnt_o, dump_addr_o, rf_raddr_o}), 64'd0);
        chk("reset_data", 64'(dump_data_o), 64'd0);
        rst_i = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic st, sp, dm, rd;
        logic cpu, hlt, dn, vld;
        logic [31:0] cnt;
    } vec_t;
    vec_t tbl [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, guard;
        logic pv, pl, rd;
        logic [4:0] pa;
        logic [31:0] pd;

        tbl[0] = '{1, 0, 0, 0,  1, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 0,  1, 0, 0, 0, 1};
        tbl[2] = '{1, 0, 0, 0,  1, 0, 0, 0, 2};
        tbl[3] = '{0, 0, 0, 0,  0, 1, 0, 0, 3};
        tbl[4] = '{0, 1, 0, 0,  1, 0, 0, 0, 3};
        tbl[5] = '{0, 0, 0, 0,  0, 1, 0, 0, 4};
        tbl[6] = '{1, 1, 1, 0,  0, 0, 0, 0, 4};
        tbl[7] = '{0, 1, 0, 0,  0, 0, 0, 1, 4};
        tbl[8] = '{1, 0, 0, 0,  0, 0, 0, 1, 4};
        tbl[9] = '{0, 0, 0, 0,  0, 0, 0, 1, 4};

        for (int i = 0; i < NREGS; i++) rf[i] = 32'(i * 3);
        rst_i = 1'b0;
        start_i = 0; step_i = 0; dump_i = 0; dump_ready_i = 0;
        #12;
        do_reset();

        // table: run, pause, step, simultaneous requests, stalled dump
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].st, tbl[i].sp, tbl[i].dm, tbl[i].rd);
            chk($sformatf("vec%0d", i),
                64'({cpu_en_o, halted_o, done_o, dump_valid_o, cycle_cnt_o}),
                64'({tbl[i].cpu, tbl[i].hlt, tbl[i].dn, tbl[i].vld, tbl[i].cnt}));
        end
        guard = 0;
        while (!halted_o && guard < 200) begin
            cyc(0, 0, 0, 1);
            guard++;
        end
        chk("simul_dump_done", 64'({halted_o, dump_valid_o, cycle_cnt_o}), 64'({1'b1, 1'b0, 32'd4}));
        cyc(0, 0, 0, 0);
        chk("step_not_repulsed", 64'({halted_o, cpu_en_o, cycle_cnt_o}), 64'({1'b1, 1'b0, 32'd4}));

        // budget run
        do_reset();
        beats = 0; guard = 0;
        while (!halted_o && guard < 100) begin
            cyc(1, 0, 0, 0);
            if (cpu_en_o) beats++;
            guard++;
        end
        chk("budget_en_cycles", 64'(beats), 64'(LIMIT));
        chk("budget_end", 64'({cycle_cnt_o, done_o, halted_o}), 64'({32'd30, 1'b1, 1'b1}));
        for (int i = 0; i < 6; i++) cyc(1, i[0], 0, 0);
        chk("budget_sticky", 64'({cycle_cnt_o, cpu_en_o}), 64'({32'd30, 1'b0}));

        // pause / step / resume
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("pause_cnt", 64'({cycle_cnt_o, halted_o}), 64'({32'd10, 1'b1}));
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            chk("step_en", 64'(cpu_en_o), 64'd1);
            cyc(0, 0, 0, 0);
            chk("step_back", 64'({cpu_en_o, halted_o}), 64'({1'b0, 1'b1}));
        end
        chk("step_cnt", 64'(cycle_cnt_o), 64'd13);
        guard = 0;
        while (!(halted_o && done_o) && guard < 100) begin
            cyc(1, 0, 0, 0);
            guard++;
        end
        chk("resume_end", 64'({cycle_cnt_o, done_o}), 64'({32'd30, 1'b1}));

        // dump with random backpressure (done is set; dump still accepted)
        cyc(0, 0, 1, 0);
        beats = 0;
        for (int k = 0; k < 600 && beats < NREGS; k++) begin
            rd = 1'($urandom_range(0, 1));
            pv = dump_valid_o; pa = dump_addr_o; pd = dump_data_o; pl = dump_last_o;
            cyc(0, 0, 0, rd);
            if (pv && rd) begin
                chk("dump_beat", 64'({pl, pa, pd}),
                    64'({(beats == NREGS - 1), 5'(beats), 32'(beats * 3)}));
                beats++;
            end else if (pv) begin
                chk("dump_hold", 64'({dump_valid_o, dump_last_o, dump_addr_o, dump_data_o}),
                    64'({1'b1, pl, pa, pd}));
            end
        end
        chk("dump_beats", 64'(beats), 64'(NREGS));
        chk("dump_end", 64'({dump_valid_o, halted_o, done_o, cycle_cnt_o}),
            64'({1'b0, 1'b1, 1'b1, 32'd30}));

        // asynchronous reset in the middle of a dump
        cyc(0, 0, 1, 0);
        guard = 0;
        while (!(dump_valid_o && dump_addr_o == 5'd5) && guard < 50) begin
            cyc(0, 0, 0, 1);
            guard++;
        end
        chk("reach_beat5", 64'({dump_valid_o, dump_addr_o}), 64'({1'b1, 5'd5}));
        #3 rst_i = 1'b0;
        #1;
        chk("async_rst", 64'({dump_valid_o, cpu_en_o, halted_o, done_o, cycle_cnt_o, dump_addr_o}), 64'd0);
        model_reset();
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        cyc(0, 0, 0, 1);
        chk("idle_after_rst", 64'({halted_o, cpu_en_o, dump_valid_o}), 64'd0);

        // unlimited budget instance
        do_reset();
        for (int i = 0; i < 101; i++) cyc(1, 0, 0, 0);
        chk("unlim_cnt", 64'({cnt0, done0, cpu_en0}), 64'({32'd100, 1'b0, 1'b1}));

        // randomized traffic against the model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
            for (int i = 0; i < 250; i++)
                cyc(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 16) == 0,
                    1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
